// File: rtl/sd_cmd_seq.sv
// SD-card SPI-mode command sequencer: drives a byte-level SPI engine through
// clock select, CS low, command frame, R1 polling and the trailing release byte.
package sd_cmd_seq_pkg;
    typedef enum logic [2:0] {
        spiNOP  = 3'd0,
        spiSLOW = 3'd1,
        spiFAST = 3'd2,
        spiCSL  = 3'd3,
        spiCSH  = 3'd4,
        spiTR   = 3'd5
    } spiOP_t;
endpackage

module sd_cmd_seq
    import sd_cmd_seq_pkg::*;
#(
    parameter int unsigned RespPolls = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmdSTART,
    input  logic [5:0]   cmdIDX,
    input  logic [31:0]  cmdARG,
    input  logic [6:0]   cmdCRC,
    input  logic         cmdFAST,
    input  logic         holdCS,
    output logic         cmdBUSY,
    output logic         cmdDONE,
    output logic [7:0]   cmdR1,
    output logic         cmdTIMEOUT,
    output spiOP_t       spiOP,
    output logic [7:0]   spiTXD,
    input  logic [7:0]   spiRXD,
    input  logic         spiDONE
);

    typedef enum logic [2:0] {
        sIDLE, sCLK, sCSL, sXFR, sWAIT, sCSH, sFIN
    } state_t;

    typedef enum logic [1:0] {
        phPRE, phCMD, phRSP, phTAIL
    } phase_t;

    localparam logic [7:0] POLL_MAX = 8'(RespPolls);

    state_t      r_state;
    state_t      w_next_state;
    phase_t      r_phase;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_poll_cnt;
    logic [7:0]  r_r1;
    logic        r_tmo;

    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    logic [6:0]  r_crc;
    logic        r_fast;
    logic        r_hold;

    logic        w_accept;
    logic        w_xfer_end;
    logic        w_rsp_hit;
    logic [7:0]  w_poll_next;
    logic        w_poll_last;
    logic [7:0]  w_cmd_byte;

    assign w_accept    = (r_state == sIDLE) && cmdSTART;
    assign w_xfer_end  = (r_state == sWAIT) && spiDONE;
    assign w_rsp_hit   = !spiRXD[7];
    // Saturate so the poll counter can never wrap back to zero.
    assign w_poll_next = (r_poll_cnt == 8'hFF) ? 8'hFF : r_poll_cnt + 8'd1;
    assign w_poll_last = (w_poll_next >= POLL_MAX);

    always_comb begin
        w_cmd_byte = 8'hFF;
        case (r_byte_cnt)
            3'd0:    w_cmd_byte = {2'b01, r_idx};
            3'd1:    w_cmd_byte = r_arg[31:24];
            3'd2:    w_cmd_byte = r_arg[23:16];
            3'd3:    w_cmd_byte = r_arg[15:8];
            3'd4:    w_cmd_byte = r_arg[7:0];
            3'd5:    w_cmd_byte = {r_crc, 1'b1};
            default: w_cmd_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= sIDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        spiOP        = spiNOP;
        spiTXD       = 8'hFF;
        cmdDONE      = 1'b0;
        cmdBUSY      = (r_state != sIDLE);
        case (r_state)
            sIDLE: begin
                if (cmdSTART) w_next_state = sCLK;
            end
            sCLK: begin
                spiOP        = r_fast ? spiFAST : spiSLOW;
                w_next_state = sCSL;
            end
            sCSL: begin
                spiOP        = spiCSL;
                w_next_state = sXFR;
            end
            sXFR: begin
                spiOP        = spiTR;
                spiTXD       = (r_phase == phCMD) ? w_cmd_byte : 8'hFF;
                w_next_state = sWAIT;
            end
            sWAIT: begin
                if (spiDONE) begin
                    case (r_phase)
                        phPRE, phCMD: w_next_state = sXFR;
                        phRSP: begin
                            // A valid R1 with holdCS keeps the card selected for the data phase.
                            if (w_rsp_hit)        w_next_state = r_hold ? sFIN : sCSH;
                            else if (w_poll_last) w_next_state = sCSH;
                            else                  w_next_state = sXFR;
                        end
                        default:      w_next_state = sFIN;
                    endcase
                end
            end
            sCSH: begin
                spiOP        = spiCSH;
                w_next_state = sXFR;
            end
            sFIN: begin
                cmdDONE      = 1'b1;
                w_next_state = sIDLE;
            end
            default: w_next_state = sIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= phPRE;
            r_byte_cnt <= 3'd0;
            r_poll_cnt <= 8'd0;
            r_r1       <= 8'hFF;
            r_tmo      <= 1'b0;
        end else if (w_accept) begin
            r_phase    <= phPRE;
            r_byte_cnt <= 3'd0;
            r_poll_cnt <= 8'd0;
            r_r1       <= 8'hFF;
            r_tmo      <= 1'b0;
        end else if (w_xfer_end) begin
            case (r_phase)
                phPRE: begin
                    r_phase    <= phCMD;
                    r_byte_cnt <= 3'd0;
                end
                phCMD: begin
                    if (r_byte_cnt == 3'd5) r_phase <= phRSP;
                    else                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
                phRSP: begin
                    if (w_rsp_hit) begin
                        r_r1 <= spiRXD;
                    end else begin
                        r_poll_cnt <= w_poll_next;
                        if (w_poll_last) begin
                            r_r1  <= 8'hFF;
                            r_tmo <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end else if (r_state == sCSH) begin
            r_phase <= phTAIL;
        end
    end

    // Command fields are pure data: loaded on accept, never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx  <= cmdIDX;
            r_arg  <= cmdARG;
            r_crc  <= cmdCRC;
            r_fast <= cmdFAST;
            r_hold <= holdCS;
        end
    end

    assign cmdR1      = r_r1;
    assign cmdTIMEOUT = r_tmo;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Scoreboard bench for sd_cmd_seq: a byte-engine model answers transfers, a
// monitor pops expected SPI ops / completions and checks engine protocol.
module tb_sd_cmd_seq;
    import sd_cmd_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmdSTART;
    logic [5:0]  cmdIDX;
    logic [31:0] cmdARG;
    logic [6:0]  cmdCRC;
    logic        cmdFAST;
    logic        holdCS;
    logic        cmdBUSY;
    logic        cmdDONE;
    logic [7:0]  cmdR1;
    logic        cmdTIMEOUT;
    spiOP_t      spiOP;
    logic [7:0]  spiTXD;
    logic [7:0]  spiRXD;
    logic        spiDONE;

    sd_cmd_seq #(.RespPolls(8)) dut (
        .clk(clk), .rst(rst),
        .cmdSTART(cmdSTART), .cmdIDX(cmdIDX), .cmdARG(cmdARG), .cmdCRC(cmdCRC),
        .cmdFAST(cmdFAST), .holdCS(holdCS),
        .cmdBUSY(cmdBUSY), .cmdDONE(cmdDONE), .cmdR1(cmdR1), .cmdTIMEOUT(cmdTIMEOUT),
        .spiOP(spiOP), .spiTXD(spiTXD), .spiRXD(spiRXD), .spiDONE(spiDONE)
    );

    typedef struct {
        logic       is_done;
        spiOP_t     op;
        logic [7:0] txd;
        logic [7:0] r1;
        logic       tmo;
    } ev_t;

    ev_t        sb_q[$];
    logic [7:0] rx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         tr_count = 0;
    int         done_cnt = 0;
    logic [7:0] hdr [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_op(input spiOP_t op, input logic [7:0] txd);
        ev_t e;
        e.is_done = 1'b0; e.op = op; e.txd = txd; e.r1 = 8'h00; e.tmo = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_done(input logic [7:0] r1, input logic tmo);
        ev_t e;
        e.is_done = 1'b1; e.op = spiNOP; e.txd = 8'h00; e.r1 = r1; e.tmo = tmo;
        sb_q.push_back(e);
    endtask

    // Clock op, CS low, then the PRE byte and six CMD bytes from hdr.
    task automatic push_hdr(input spiOP_t clkop);
        push_op(clkop, 8'h00);
        push_op(spiCSL, 8'h00);
        for (int i = 0; i < 7; i++) push_op(spiTR, hdr[i]);
    endtask

    task automatic set_rx(input int n_ff, input logic [7:0] resp);
        rx_q.delete();
        for (int i = 0; i < n_ff; i++) rx_q.push_back(8'hFF);
        rx_q.push_back(resp);
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                             input logic fast, input logic hold);
        @(posedge clk); #1;
        cmdIDX = idx; cmdARG = arg; cmdCRC = crc; cmdFAST = fast; holdCS = hold;
        cmdSTART = 1'b1;
        @(posedge clk); #1;
        cmdSTART = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || cmdBUSY) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_pending_events"}, 32'(sb_q.size()), 32'd0);
        chk({name, "_busy_after"}, 32'(cmdBUSY), 32'd0);
        sb_q.delete();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_op"}, 32'(spiOP), 32'(spiNOP));
        chk({name, "_txd"}, 32'(spiTXD), 32'hFF);
        chk({name, "_busy"}, 32'(cmdBUSY), 32'd0);
        chk({name, "_done"}, 32'(cmdDONE), 32'd0);
        chk({name, "_r1"}, 32'(cmdR1), 32'hFF);
        chk({name, "_tmo"}, 32'(cmdTIMEOUT), 32'd0);
    endtask

    // Byte-engine model: spiDONE two cycles after a spiTR, RX from rx_q (idle line = FF).
    initial begin
        int cnt;
        cnt = 0;
        spiDONE = 1'b0;
        spiRXD = 8'hFF;
        forever begin
            @(posedge clk); #1;
            spiDONE = 1'b0;
            if (!rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        spiDONE = 1'b1;
                        spiRXD = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                    end
                end
                if (spiOP == spiTR) cnt = 2;
            end
        end
    end

    // Monitor: protocol checks plus in-order scoreboard of ops and completions.
    initial begin
        logic   pending;
        spiOP_t prev_op;
        ev_t    e;
        pending = 1'b0;
        prev_op = spiNOP;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending = 1'b0;
                prev_op = spiNOP;
            end else begin
                if (spiOP != spiNOP) begin
                    chk("proto_op_during_transfer", 32'(pending), 32'd0);
                    chk("proto_op_width", 32'(spiOP == prev_op), 32'd0);
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_op: got op %0d txd %0h, none expected", spiOP, spiTXD);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.is_done) begin
                            checks++; errors++;
                            $display("FAIL event_order: got op %0d, expected cmdDONE", spiOP);
                        end else begin
                            chk("spi_op", 32'(spiOP), 32'(e.op));
                            if (e.op == spiTR) chk("spi_txd", 32'(spiTXD), 32'(e.txd));
                        end
                    end
                    if (spiOP == spiTR) begin
                        pending = 1'b1;
                        tr_count++;
                    end
                end
                if (spiDONE) pending = 1'b0;
                if (cmdDONE) begin
                    done_cnt++;
                    chk("busy_with_done", 32'(cmdBUSY), 32'd1);
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got cmdDONE r1 %0h, none expected", cmdR1);
                    end else begin
                        e = sb_q.pop_front();
                        if (!e.is_done) begin
                            checks++; errors++;
                            $display("FAIL event_order: got cmdDONE, expected op %0d", e.op);
                        end else begin
                            chk("done_r1", 32'(cmdR1), 32'(e.r1));
                            chk("done_timeout", 32'(cmdTIMEOUT), 32'(e.tmo));
                        end
                    end
                end
                prev_op = spiOP;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; cmdSTART = 1'b0; cmdIDX = 6'd0; cmdARG = 32'd0;
        cmdCRC = 7'd0; cmdFAST = 1'b0; holdCS = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        // CMD0, slow, R1 = 01 on second poll
        hdr = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        push_hdr(spiSLOW);
        push_op(spiTR, 8'hFF); push_op(spiTR, 8'hFF);
        push_op(spiCSH, 8'h00); push_op(spiTR, 8'hFF);
        push_done(8'h01, 1'b0);
        set_rx(8, 8'h01);
        start_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0);
        chk("cmd0_busy_running", 32'(cmdBUSY), 32'd1);
        wait_done("cmd0");
        chk("cmd0_r1_held", 32'(cmdR1), 32'h01);

        // CMD8 with MISO stuck high: eight polls then timeout
        hdr = '{8'hFF, 8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
        push_hdr(spiSLOW);
        for (int i = 0; i < 8; i++) push_op(spiTR, 8'hFF);
        push_op(spiCSH, 8'h00); push_op(spiTR, 8'hFF);
        push_done(8'hFF, 1'b1);
        rx_q.delete();
        start_cmd(6'd8, 32'h000001AA, 7'h43, 1'b0, 1'b0);
        wait_done("timeout");
        chk("timeout_flag_held", 32'(cmdTIMEOUT), 32'd1);
        chk("timeout_r1_held", 32'(cmdR1), 32'hFF);

        // CMD17, fast, holdCS: no CSH, no TAIL
        hdr = '{8'hFF, 8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'h55};
        push_hdr(spiFAST);
        push_op(spiTR, 8'hFF); push_op(spiTR, 8'hFF);
        push_done(8'h00, 1'b0);
        set_rx(8, 8'h00);
        start_cmd(6'd17, 32'h00001234, 7'h2A, 1'b1, 1'b1);
        wait_done("holdcs");
        chk("holdcs_r1_held", 32'(cmdR1), 32'h00);
        chk("holdcs_tmo_cleared", 32'(cmdTIMEOUT), 32'd0);

        // CMD1 with stray cmdSTART while busy and in the cmdDONE cycle
        hdr = '{8'hFF, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF9};
        push_hdr(spiSLOW);
        push_op(spiTR, 8'hFF);
        push_op(spiCSH, 8'h00); push_op(spiTR, 8'hFF);
        push_done(8'h01, 1'b0);
        set_rx(7, 8'h01);
        start_cmd(6'd1, 32'h0, 7'h7C, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_mid_cmd", 32'(cmdBUSY), 32'd1);
        cmdIDX = 6'd2; cmdSTART = 1'b1;
        @(posedge clk); #1;
        cmdSTART = 1'b0;
        n = 0;
        while (!cmdDONE && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_done_seen", 32'(cmdDONE), 32'd1);
        cmdSTART = 1'b1;
        @(posedge clk); #1;
        cmdSTART = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        wait_done("busy");
        chk("done_count_after_busy", 32'(done_cnt), 32'd4);

        // Reset during third CMD byte, then a full CMD55
        hdr = '{8'hFF, 8'h49, 8'hA5, 8'hC3, 8'h00, 8'h00, 8'h00};
        push_op(spiSLOW, 8'h00); push_op(spiCSL, 8'h00);
        for (int i = 0; i < 4; i++) push_op(spiTR, hdr[i]);
        rx_q.delete();
        n = tr_count + 4;
        start_cmd(6'd9, 32'hA5C30000, 7'h11, 1'b0, 1'b0);
        while (tr_count < n && cmdBUSY) begin
            @(posedge clk); #1;
        end
        chk("rst_reached_byte3", 32'(tr_count), 32'(n));
        rst = 1'b0;
        #1;
        check_reset("midreset");
        chk("midreset_pending_events", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        hdr = '{8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
        push_hdr(spiSLOW);
        push_op(spiTR, 8'hFF);
        push_op(spiCSH, 8'h00); push_op(spiTR, 8'hFF);
        push_done(8'h01, 1'b0);
        set_rx(7, 8'h01);
        start_cmd(6'd55, 32'h0, 7'h32, 1'b0, 1'b0);
        wait_done("after_reset");
        chk("done_count_final", 32'(done_cnt), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
